// File: rtl/count_seq_ctrl_if.sv
// Command and status bundle for the LED count sequencer: push-button pulses,
// count configuration in, registered count/status out.
interface count_seq_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             pause;
    logic             stop;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             dir;
    logic             mode;
    logic [CNT_W-1:0] cnt_lim;
    logic [CNT_W-1:0] q;
    logic             tick;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, pause, stop, load, load_val, dir, mode, cnt_lim,
        input  q, tick, busy, done, state
    );

    modport slave (
        input  start, pause, stop, load, load_val, dir, mode, cnt_lim,
        output q, tick, busy, done, state
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Run/pause/stop sequencer for the slow LED counter: a prescaler produces a
// one-cycle step enable and the count steps up or down, wrapping or one-shot.
module count_seq_ctrl #(
    parameter int                 CNT_W     = 4,
    parameter int                 PRESC_W   = 26,
    parameter logic [PRESC_W-1:0] PRESC_MAX = {PRESC_W{1'b1}}
) (
    input  logic            clk,
    input  logic            reset,
    count_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};

    state_t             state_r, state_s;
    logic [PRESC_W-1:0] presc_r, presc_s;
    logic [CNT_W-1:0]   q_r, q_s;
    logic               tick_r, tick_s;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W:0]     step_s;

    // Returns {limit_hit_one_shot, next_count}; a hit leaves the count unchanged.
    function automatic logic [CNT_W:0] step_count(
        input logic [CNT_W-1:0] cur,
        input logic [CNT_W-1:0] lim,
        input logic             down,
        input logic             one_shot
    );
        logic [CNT_W:0] res;
        if (!down) begin
            if (cur >= lim) begin
                res = one_shot ? {1'b1, cur} : {1'b0, CNT_ZERO};
            end else begin
                res = {1'b0, cur + CNT_ONE};
            end
        end else begin
            if (cur == CNT_ZERO) begin
                res = one_shot ? {1'b1, cur} : {1'b0, lim};
            end else begin
                res = {1'b0, cur - CNT_ONE};
            end
        end
        return res;
    endfunction

    // Next-state, prescaler and count update with stop > load > start > pause.
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        q_s     = q_r;
        tick_s  = 1'b0;
        step_s  = step_count(q_r, bus.cnt_lim, bus.dir, bus.mode);

        if (bus.stop) begin
            q_s     = CNT_ZERO;
            presc_s = PRESC_ZERO;
            state_s = ST_IDLE;
        end else if (bus.load) begin
            q_s     = bus.load_val;
            presc_s = PRESC_ZERO;
            if (state_r == ST_DONE) begin
                state_s = ST_IDLE;
            end else begin
                state_s = state_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    presc_s = PRESC_ZERO;
                    if (bus.start) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // start outranks pause, and start is a no-op while running
                    if (bus.pause && !bus.start) begin
                        state_s = ST_PAUSE;
                    end else if (presc_r == PRESC_MAX) begin
                        presc_s = PRESC_ZERO;
                        tick_s  = 1'b1;
                        q_s     = step_s[CNT_W-1:0];
                        if (step_s[CNT_W]) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        presc_s = presc_r + PRESC_ONE;
                    end
                end
                ST_PAUSE: begin
                    if (bus.start || bus.pause) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        state_s = ST_RUN;
                        presc_s = PRESC_ZERO;
                        q_s     = bus.dir ? bus.cnt_lim : CNT_ZERO;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    presc_s = PRESC_ZERO;
                    q_s     = CNT_ZERO;
                end
            endcase
        end
    end

    // State and output registers; busy/done decode the next state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            presc_r <= PRESC_ZERO;
            q_r     <= CNT_ZERO;
            tick_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            presc_r <= presc_s;
            q_r     <= q_s;
            tick_r  <= tick_s;
            busy_r  <= (state_s == ST_RUN) || (state_s == ST_PAUSE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign bus.q     = q_r;
    assign bus.tick  = tick_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.state = state_r;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench: tick events are popped from per-instance expectation queues
// by a negedge monitor; direct checks cover reset, pause, stop and load cases.
module tb_count_seq_ctrl;

    typedef struct packed {
        logic [3:0] q;
        logic [1:0] state;
        logic       busy;
        logic       done;
        logic [7:0] gap;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    int   cyc;
    int   last_a;
    int   last_b;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    count_seq_ctrl_if #(.CNT_W(4)) a_if ();
    count_seq_ctrl_if #(.CNT_W(4)) b_if ();

    count_seq_ctrl #(.CNT_W(4), .PRESC_W(26), .PRESC_MAX(26'd3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    count_seq_ctrl #(.CNT_W(4), .PRESC_W(26), .PRESC_MAX(26'd0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every tick must match the oldest expectation of its instance
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset && a_if.tick) begin
            n_cmp = n_cmp + 1;
            if (qa.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL a_unexpected_tick q=%0d state=%0d", a_if.q, a_if.state);
            end else begin
                ea = qa.pop_front();
                if ({a_if.q, a_if.state, a_if.busy, a_if.done} !== {ea.q, ea.state, ea.busy, ea.done}) begin
                    n_fail = n_fail + 1;
                    $display("FAIL a_tick got q=%0d st=%0d busy=%0b done=%0b want q=%0d st=%0d busy=%0b done=%0b",
                             a_if.q, a_if.state, a_if.busy, a_if.done, ea.q, ea.state, ea.busy, ea.done);
                end
                if (ea.gap != 8'd0) begin
                    n_cmp = n_cmp + 1;
                    if (cyc - last_a != int'(ea.gap)) begin
                        n_fail = n_fail + 1;
                        $display("FAIL a_tick_period got=%0d want=%0d", cyc - last_a, ea.gap);
                    end
                end
            end
            last_a = cyc;
        end
        if (reset && b_if.tick) begin
            n_cmp = n_cmp + 1;
            if (qb.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL b_unexpected_tick q=%0d state=%0d", b_if.q, b_if.state);
            end else begin
                eb = qb.pop_front();
                if ({b_if.q, b_if.state, b_if.busy, b_if.done} !== {eb.q, eb.state, eb.busy, eb.done}) begin
                    n_fail = n_fail + 1;
                    $display("FAIL b_tick got q=%0d st=%0d want q=%0d st=%0d",
                             b_if.q, b_if.state, eb.q, eb.state);
                end
                if (eb.gap != 8'd0) begin
                    n_cmp = n_cmp + 1;
                    if (cyc - last_b != int'(eb.gap)) begin
                        n_fail = n_fail + 1;
                        $display("FAIL b_tick_period got=%0d want=%0d", cyc - last_b, eb.gap);
                    end
                end
            end
            last_b = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp = n_cmp + 1;
        if (act !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0d want=%0d", name, act, exp_v);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // cmd = {stop, load, start, pause}; sel 0 drives instance A, 1 drives B
    task automatic pulse(input logic sel, input logic [3:0] cmd);
        if (!sel) {a_if.stop, a_if.load, a_if.start, a_if.pause} = cmd;
        else      {b_if.stop, b_if.load, b_if.start, b_if.pause} = cmd;
        cycle();
        if (!sel) {a_if.stop, a_if.load, a_if.start, a_if.pause} = 4'b0000;
        else      {b_if.stop, b_if.load, b_if.start, b_if.pause} = 4'b0000;
    endtask

    task automatic push_a(input logic [3:0] q, input logic [1:0] st, input logic busy,
                          input logic done, input logic [7:0] gap);
        exp_t e;
        e.q = q; e.state = st; e.busy = busy; e.done = done; e.gap = gap;
        qa.push_back(e);
    endtask

    task automatic drain(input logic sel, input int budget);
        int n;
        n = 0;
        while (((!sel && qa.size() != 0) || (sel && qb.size() != 0)) && n < budget) begin
            @(negedge clk);
            #2;
            n = n + 1;
        end
        n_cmp = n_cmp + 1;
        if (!sel && qa.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL a_drain pending=%0d", qa.size());
            qa.delete();
        end else if (sel && qb.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL b_drain pending=%0d", qb.size());
            qb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        n_cmp = 0; n_fail = 0; cyc = 0; last_a = 0; last_b = 0;
        reset = 1'b0;
        {a_if.stop, a_if.load, a_if.start, a_if.pause} = 4'b0000;
        {b_if.stop, b_if.load, b_if.start, b_if.pause} = 4'b0000;
        a_if.load_val = 4'd0; a_if.dir = 1'b0; a_if.mode = 1'b0; a_if.cnt_lim = 4'd9;
        b_if.load_val = 4'd0; b_if.dir = 1'b0; b_if.mode = 1'b0; b_if.cnt_lim = 4'd15;

        #12;
        chk("rst_q", 32'(a_if.q), 32'd0);
        chk("rst_state", 32'(a_if.state), 32'd0);
        chk("rst_tick_busy_done", 32'({a_if.tick, a_if.busy, a_if.done}), 32'd0);
        chk("rst_b_state", 32'(b_if.state), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Up-count wrap at 9, tick every 4 clk, then async reset mid-run at q=5
        push_a(4'd1, 2'd1, 1'b1, 1'b0, 8'd0);
        for (int i = 2; i <= 9; i++) push_a(4'(i), 2'd1, 1'b1, 1'b0, 8'd4);
        push_a(4'd0, 2'd1, 1'b1, 1'b0, 8'd4);
        for (int i = 1; i <= 5; i++) push_a(4'(i), 2'd1, 1'b1, 1'b0, 8'd4);
        pulse(1'b0, 4'b0010);
        drain(1'b0, 80);
        reset = 1'b0;
        #1;
        chk("async_rst_q", 32'(a_if.q), 32'd0);
        chk("async_rst_state", 32'(a_if.state), 32'd0);
        chk("async_rst_tick", 32'(a_if.tick), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Load 7, count down one-shot to DONE, restart from cnt_lim
        a_if.load_val = 4'd7; a_if.dir = 1'b1; a_if.mode = 1'b1; a_if.cnt_lim = 4'd9;
        pulse(1'b0, 4'b0100);
        chk("load_q", 32'(a_if.q), 32'd7);
        push_a(4'd6, 2'd1, 1'b1, 1'b0, 8'd0);
        for (int i = 5; i >= 0; i--) push_a(4'(i), 2'd1, 1'b1, 1'b0, 8'd4);
        push_a(4'd0, 2'd3, 1'b0, 1'b1, 8'd4);
        pulse(1'b0, 4'b0010);
        drain(1'b0, 50);
        repeat (8) cycle();
        chk("done_q_hold", 32'(a_if.q), 32'd0);
        chk("done_state", 32'(a_if.state), 32'd3);
        chk("done_level", 32'(a_if.done), 32'd1);
        pulse(1'b0, 4'b0010);
        chk("restart_q", 32'(a_if.q), 32'd9);
        chk("restart_state", 32'(a_if.state), 32'd1);
        chk("restart_busy_done", 32'({a_if.busy, a_if.done}), 32'd2);
        pulse(1'b0, 4'b1000);
        chk("stop_q", 32'(a_if.q), 32'd0);

        // Pause two clk after a tick keeps prescaler phase
        a_if.dir = 1'b0; a_if.mode = 1'b0;
        push_a(4'd1, 2'd1, 1'b1, 1'b0, 8'd0);
        pulse(1'b0, 4'b0010);
        drain(1'b0, 10);
        cycle();
        cycle();
        pulse(1'b0, 4'b0001);
        repeat (20) cycle();
        chk("paused_q", 32'(a_if.q), 32'd1);
        chk("paused_state_busy", 32'({a_if.state, a_if.busy}), 32'b101);
        push_a(4'd2, 2'd1, 1'b1, 1'b0, 8'd0);
        pulse(1'b0, 4'b0001);
        cycle();
        chk("resume_no_early_tick", 32'(a_if.tick), 32'd0);
        cycle();
        chk("resume_tick_2clk", 32'({a_if.tick, a_if.q}), 32'({1'b1, 4'd2}));

        // Stop and load together: stop wins
        a_if.load_val = 4'd7;
        pulse(1'b0, 4'b1100);
        chk("stop_load_q", 32'(a_if.q), 32'd0);
        chk("stop_load_state", 32'(a_if.state), 32'd0);
        drain(1'b0, 2);

        // Load on the tick edge wins; next tick wraps because 12 >= cnt_lim
        pulse(1'b0, 4'b0010);
        cycle(); cycle(); cycle();
        a_if.load_val = 4'd12;
        pulse(1'b0, 4'b0100);
        chk("load_on_tick_q", 32'(a_if.q), 32'd12);
        chk("load_on_tick_no_tick", 32'({a_if.tick, a_if.state}), 32'd1);
        push_a(4'd0, 2'd1, 1'b1, 1'b0, 8'd0);
        drain(1'b0, 12);
        pulse(1'b0, 4'b1000);

        // Down-count from above cnt_lim steps normally
        a_if.dir = 1'b1;
        pulse(1'b0, 4'b0100);
        push_a(4'd11, 2'd1, 1'b1, 1'b0, 8'd0);
        push_a(4'd10, 2'd1, 1'b1, 1'b0, 8'd4);
        pulse(1'b0, 4'b0010);
        drain(1'b0, 15);
        pulse(1'b0, 4'b1000);

        // PRESC_MAX=0: tick every clk, wrap 15 -> 0
        b_if.load_val = 4'd13;
        pulse(1'b1, 4'b0100);
        e.state = 2'd1; e.busy = 1'b1; e.done = 1'b0;
        e.q = 4'd14; e.gap = 8'd0; qb.push_back(e);
        e.q = 4'd15; e.gap = 8'd1; qb.push_back(e);
        e.q = 4'd0;  e.gap = 8'd1; qb.push_back(e);
        e.q = 4'd1;  e.gap = 8'd1; qb.push_back(e);
        pulse(1'b1, 4'b0010);
        cycle();
        cycle();
        chk("b_tick_held", 32'(b_if.tick), 32'd1);
        cycle();
        cycle();
        pulse(1'b1, 4'b1000);
        chk("b_stop_q_tick", 32'({b_if.q, b_if.tick}), 32'd0);
        drain(1'b1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
